rns_residue_arbiter: RTL
========================

Name: rns_residue_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit residue channel between two requesters (A, B).
- Drives the select line of the 2:1 residue mux (select=0 picks A, select=1 picks B) and registers the mux result into a one-entry output stage with valid/ready handshake.
- Sits in front of the RNS modular arithmetic units, where channel A and channel B residues compete for one shared adder/multiplier lane.

Parameters:
- WIDTH, 4, residue width in bits (matches the 4-bit mux).
- MAX_BURST, 4, max consecutive transfers granted to one requester while the other is waiting; must be >= 1.
- CNT_W, 2, burst counter width; must satisfy 2^CNT_W >= MAX_BURST.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a residue.
- a_data  in  WIDTH  requester A residue.
- a_ready  out  1  A transfer accepted this cycle when a_valid && a_ready.
- b_valid  in  1  requester B has a residue.
- b_data  in  WIDTH  requester B residue.
- b_ready  out  1  B transfer accepted this cycle when b_valid && b_ready.
- select  out  1  registered mux select: 0 = A, 1 = B.
- out_valid  out  1  output stage holds a residue.
- out_data  out  WIDTH  registered mux result.
- out_src  out  1  source of out_data: 0 = A, 1 = B.
- out_ready  in  1  downstream accepts out_data when out_valid && out_ready.

Behaviour:
- Interface is decided: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset values:
  - state=IDLE; out_valid=0; out_data=0; out_src=0; select=0; burst_cnt=0.
  - last_served=B, so A wins the first tie.
  - a_ready and b_ready are 0 during reset and in the cycle after.
- States: IDLE, SERVE_A, SERVE_B. Outputs track state: select=1 only in SERVE_B; it is 0 in IDLE and SERVE_A.
- Ready rules (combinational):
  - space = !out_valid || out_ready.
  - a_ready = (state==SERVE_A) && space.
  - b_ready = (state==SERVE_B) && space.
  - Never both high. Ready never depends on its own valid.
- IDLE transitions:
  - Only a_valid -> SERVE_A.
  - Only b_valid -> SERVE_B.
  - Both valid -> serve the requester != last_served.
  - Neither -> stay.
  - No transfer occurs in IDLE; arbitration costs 1 cycle.
- SERVE_X (Y = the other requester), evaluated each edge in priority order:
  1. Transfer and burst_cnt==MAX_BURST-1: burst_cnt<=0. If y_valid -> SERVE_Y and last_served<=X; else stay in SERVE_X (a fresh burst).
  2. Transfer otherwise: burst_cnt<=burst_cnt+1.
  3. !x_valid: burst_cnt<=0 and last_served<=X. If y_valid -> SERVE_Y directly with no IDLE bubble; else -> IDLE.
  4. x_valid but stalled (!space): hold state and burst_cnt.
- Output stage:
  - On any transfer: out_data<=mux(a_data,b_data,select), out_src<=select, out_valid<=1.
  - Else if out_ready: out_valid<=0.
  - While out_valid && !out_ready, out_data and out_src are held stable.
  - Throughput: 1 word/cycle with out_ready held high.
- Latency: requester valid in IDLE at cycle N -> ready at cycle N+1 -> out_valid at N+2.
- Fairness: with both requesters saturated and out_ready=1, grants alternate in bursts of exactly MAX_BURST transfers.
- A requester dropping valid mid-burst forfeits the rest of its burst.
- Reset mid-operation discards the held output word and any partial burst.

Test Plan:
- Reset, then a_valid=1, a_data=4'h5, out_ready=1 (A alone) -> a_ready=1 one cycle after valid; next cycle out_valid=1, out_data=4'h5, out_src=0, select=0.
- Both requesters saturated, MAX_BURST=4, A sends 1,2,3,4,5,6, B sends 9,A,B,C,D, out_ready=1 -> out_data sequence 1,2,3,4,9,A,B,C,5,6…; select rises in the cycle after the 4th A transfer; no idle cycle at the switch.
- out_valid=1 with out_ready=0 for 3 cycles, a_valid=1 -> a_ready=0, out_data stable, burst_cnt unchanged; out_ready=1 -> transfer resumes the same cycle.
- SERVE_A, A deasserts after 2 transfers, b_valid=1 -> direct SERVE_B, select=1, next B word on out_data with out_src=1; then both idle -> IDLE, both readies 0.
- Only A valid for 10 transfers, MAX_BURST=4 -> stays SERVE_A throughout, 10 words delivered back-to-back, burst_cnt wraps 0..3.
- rst asserted mid-burst with out_valid=1 -> next cycle out_valid=0, out_data=0, select=0, IDLE; with both then valid, A is granted first.

Source files
------------

// File: rtl/rns_residue_arbiter_if.sv
// Handshake bundle between two residue requesters, the shared-lane arbiter and
// the downstream modular arithmetic unit.
interface rns_residue_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             select;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, select, out_valid, out_data, out_src
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, select, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rns_residue_arbiter.sv
// Burst-limited round-robin arbiter sharing one residue lane between requesters
// A and B, with a one-entry registered output stage.
module rns_residue_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 2
) (
  input logic                  clk,
  input logic                  rst,
  rns_residue_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] burstCnt_q, burstCnt_d;
  logic             lastServed_q, lastServed_d;
  logic             outValid_q;
  logic [WIDTH-1:0] outData_q;
  logic             outSrc_q;

  logic space;
  logic aReady;
  logic bReady;
  logic curSrc;
  logic curValid;
  logic otherValid;
  logic transfer;
  logic burstEnd;

  // Readies are masked during reset so no word slips in while state is being cleared.
  assign space      = !outValid_q || bus.out_ready;
  assign aReady     = (state_q == SERVE_A) && space && !rst;
  assign bReady     = (state_q == SERVE_B) && space && !rst;
  assign curSrc     = (state_q == SERVE_B);
  assign curValid   = curSrc ? bus.b_valid : bus.a_valid;
  assign otherValid = curSrc ? bus.a_valid : bus.b_valid;
  assign transfer   = (aReady && bus.a_valid) || (bReady && bus.b_valid);
  assign burstEnd   = (burstCnt_q == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      burstCnt_q   <= '0;
      lastServed_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      burstCnt_q   <= burstCnt_d;
      lastServed_q <= lastServed_d;
    end
  end

  // lastServed: 0 = A, 1 = B; it only changes when ownership is handed over.
  always_comb begin
    state_d      = state_q;
    burstCnt_d   = burstCnt_q;
    lastServed_d = lastServed_q;
    case (state_q)
      IDLE: begin
        if (bus.a_valid && bus.b_valid) begin
          state_d = lastServed_q ? SERVE_A : SERVE_B;
        end else if (bus.a_valid) begin
          state_d = SERVE_A;
        end else if (bus.b_valid) begin
          state_d = SERVE_B;
        end
      end
      SERVE_A, SERVE_B: begin
        if (transfer) begin
          if (burstEnd) begin
            burstCnt_d = '0;
            if (otherValid) begin
              state_d      = curSrc ? SERVE_A : SERVE_B;
              lastServed_d = curSrc;
            end
          end else begin
            burstCnt_d = burstCnt_q + CNT_W'(1);
          end
        end else if (!curValid) begin
          burstCnt_d   = '0;
          lastServed_d = curSrc;
          state_d      = otherValid ? (curSrc ? SERVE_A : SERVE_B) : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outSrc_q   <= 1'b0;
    end else if (transfer) begin
      outValid_q <= 1'b1;
      outData_q  <= curSrc ? bus.b_data : bus.a_data;
      outSrc_q   <= curSrc;
    end else if (bus.out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign bus.a_ready   = aReady;
  assign bus.b_ready   = bReady;
  assign bus.select    = curSrc;
  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_src   = outSrc_q;

endmodule
